// File: rtl/game_control_pkg.sv
// Shared state/direction codes and sizing constants for the snake control path.
// Imported by the control stage, the game logic and the renderer.
package game_control_pkg;

  typedef enum logic [2:0] {
    STATE_MENU   = 3'd0,
    STATE_INGAME = 3'd1,
    STATE_OVER   = 3'd2,
    STATE_WON    = 3'd3,
    STATE_TEST   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LEFT_DIR  = 2'b00,
    TOP_DIR   = 2'b01,
    RIGHT_DIR = 2'b10,
    DOWN_DIR  = 2'b11
  } dir_e;

  localparam int TAIL_SIZE         = 7;
  localparam int MAX_TAILS_DEFAULT = 100;

  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/game_control_button_debounce.sv
// Two-flop synchroniser followed by a streak-counting debouncer for one raw input.
// Emits the debounced level and a one-cycle pulse on each accepted rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta_r;
  logic          sync_r;
  logic [CW-1:0] streak_r;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= raw;
      sync_r      <= sync_meta_r;
    end
  end

  // Flip the level only after an unbroken streak of disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level    <= 1'b0;
      press    <= 1'b0;
      streak_r <= '0;
    end else begin
      press <= 1'b0;
      if (sync_r != level) begin
        if (streak_r == LAST_COUNT) begin
          level    <= sync_r;
          press    <= sync_r;
          streak_r <= '0;
        end else begin
          streak_r <= streak_r + CW'(1);
        end
      end else begin
        streak_r <= '0;
      end
    end
  end

endmodule

// File: rtl/game_control.sv
// Snake control stage: conditions the buttons, owns the game state machine,
// the heading register and the round timer.
module game_control
  import game_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIME_LIMIT      = 3600,
  parameter int MAX_TAILS       = MAX_TAILS_DEFAULT
) (
  input  logic                 update_clk,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_start,
  input  logic                 sw_test,
  input  logic                 game_over,
  input  logic                 game_won,
  input  logic [TAIL_SIZE-1:0] tail_count,
  output logic [2:0]           game_state,
  output logic [1:0]           direction,
  output logic [11:0]          time_left,
  output logic                 time_max
);

  localparam logic [11:0]          TIME_INIT = 12'(TIME_LIMIT);
  localparam logic [TAIL_SIZE-1:0] WIN_TAILS = TAIL_SIZE'(MAX_TAILS);

  logic [4:0] btn_raw_s;
  logic [4:0] btn_press_s;
  logic [4:0] btn_level_unused_s;
  logic       test_level_s;
  logic       test_press_unused_s;

  state_e      state_r;
  dir_e        dir_r;
  logic [11:0] time_left_r;
  logic        time_max_r;
  logic        steer_valid_s;
  dir_e        steer_dir_s;

  assign btn_raw_s = {btn_start, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (update_clk),
      .reset (reset),
      .raw   (btn_raw_s[i]),
      .level (btn_level_unused_s[i]),
      .press (btn_press_s[i])
    );
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_test (
    .clk   (update_clk),
    .reset (reset),
    .raw   (sw_test),
    .level (test_level_s),
    .press (test_press_unused_s)
  );

  // Pick a single steering request: up > down > left > right.
  always_comb begin
    steer_valid_s = 1'b1;
    steer_dir_s   = RIGHT_DIR;
    if (btn_press_s[0]) begin
      steer_dir_s = TOP_DIR;
    end else if (btn_press_s[1]) begin
      steer_dir_s = DOWN_DIR;
    end else if (btn_press_s[2]) begin
      steer_dir_s = LEFT_DIR;
    end else if (btn_press_s[3]) begin
      steer_dir_s = RIGHT_DIR;
    end else begin
      steer_valid_s = 1'b0;
    end
  end

  // Game state machine together with heading and round timer.
  always_ff @(posedge update_clk or posedge reset) begin
    if (reset) begin
      state_r     <= STATE_MENU;
      dir_r       <= RIGHT_DIR;
      time_left_r <= TIME_INIT;
      time_max_r  <= 1'b0;
    end else begin
      time_max_r <= (state_r == STATE_INGAME) && (time_left_r == 12'd0);
      case (state_r)
        STATE_MENU: begin
          if (test_level_s) begin
            state_r <= STATE_TEST;
          end else if (btn_press_s[4]) begin
            state_r     <= STATE_INGAME;
            dir_r       <= RIGHT_DIR;
            time_left_r <= TIME_INIT;
          end
        end
        STATE_INGAME: begin
          // A loss outranks a win landing in the same cycle.
          if (game_over || time_max_r) begin
            state_r <= STATE_OVER;
          end else if (game_won || (tail_count >= WIN_TAILS)) begin
            state_r <= STATE_WON;
          end
          if (time_left_r != 12'd0) begin
            time_left_r <= time_left_r - 12'd1;
          end
          if (steer_valid_s && (steer_dir_s != opposite_dir(dir_r))) begin
            dir_r <= steer_dir_s;
          end
        end
        STATE_OVER, STATE_WON: begin
          if (btn_press_s[4]) begin
            state_r <= STATE_MENU;
          end
        end
        STATE_TEST: begin
          if (!test_level_s) begin
            state_r <= STATE_MENU;
          end
        end
        default: state_r <= STATE_MENU;
      endcase
    end
  end

  assign game_state = state_r;
  assign direction  = dir_r;
  assign time_left  = time_left_r;
  assign time_max   = time_max_r;

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: directed scenarios plus randomized
// button/feedback traffic compared every cycle against a behavioural model.
module tb_game_control;

  localparam int DC = 4;
  localparam int TL = 3600;
  localparam int MT = 20;
  localparam int W  = game_control_pkg::TAIL_SIZE;

  logic         update_clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic         btn_start = 1'b0, sw_test = 1'b0;
  logic         game_over = 1'b0, game_won = 1'b0;
  logic [W-1:0] tail_count = '0;
  logic [2:0]   game_state;
  logic [1:0]   direction;
  logic [11:0]  time_left;
  logic         time_max;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: raw input history, debounced levels, press pulses, game view.
  bit [2:0]  rawh [6];
  bit [15:0] samph [6];
  bit        mlvl [6];
  bit        mpress [6];
  int        m_state, m_dir, m_tl;
  bit        m_tmax;

  game_control #(.DEBOUNCE_CYCLES(DC), .TIME_LIMIT(TL), .MAX_TAILS(MT)) dut (
    .update_clk (update_clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_start  (btn_start),
    .sw_test    (sw_test),
    .game_over  (game_over),
    .game_won   (game_won),
    .tail_count (tail_count),
    .game_state (game_state),
    .direction  (direction),
    .time_left  (time_left),
    .time_max   (time_max)
  );

  always #5 update_clk = ~update_clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      rawh[i] = '0; samph[i] = '0; mlvl[i] = 1'b0; mpress[i] = 1'b0;
    end
    m_state = 0; m_dir = 2; m_tl = TL; m_tmax = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic model_edge();
    int  n_state, n_dir, n_tl, want;
    bit  n_tmax, flip;
    bit [5:0] raw;
    raw = {sw_test, btn_start, btn_right, btn_left, btn_down, btn_up};
    n_state = m_state; n_dir = m_dir; n_tl = m_tl;
    n_tmax = (m_state == 1) && (m_tl == 0);
    case (m_state)
      0: begin
        if (mlvl[5]) n_state = 4;
        else if (mpress[4]) begin n_state = 1; n_dir = 2; n_tl = TL; end
      end
      1: begin
        if (game_over || m_tmax) n_state = 2;
        else if (game_won || int'(tail_count) >= MT) n_state = 3;
        if (m_tl > 0) n_tl = m_tl - 1;
        want = -1;
        if (mpress[0]) want = 1;
        else if (mpress[1]) want = 3;
        else if (mpress[2]) want = 0;
        else if (mpress[3]) want = 2;
        if (want >= 0 && want != (m_dir ^ 2)) n_dir = want;
      end
      2, 3: if (mpress[4]) n_state = 0;
      4: if (!mlvl[5]) n_state = 0;
      default: n_state = 0;
    endcase
    // A level flips once the last DC synchronised samples (raw delayed two edges) all disagree with it.
    for (int i = 0; i < 6; i++) begin
      rawh[i]  = {rawh[i][1:0], raw[i]};
      samph[i] = {samph[i][14:0], rawh[i][2]};
      flip = 1'b1;
      for (int j = 0; j < DC; j++) if (samph[i][j] == mlvl[i]) flip = 1'b0;
      mpress[i] = flip && !mlvl[i];
      if (flip) mlvl[i] = !mlvl[i];
    end
    m_state = n_state; m_dir = n_dir; m_tl = n_tl; m_tmax = n_tmax;
  endtask

  task automatic step();
    model_edge();
    @(posedge update_clk);
    #1;
    check_value("state", int'(game_state), m_state);
    check_value("dir", int'(direction), m_dir);
    check_value("time_left", int'(time_left), m_tl);
    check_value("time_max", int'(time_max), int'(m_tmax));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_state"}, int'(game_state), 0);
    check_value({tag, "_dir"}, int'(direction), 2);
    check_value({tag, "_time_left"}, int'(time_left), TL);
    check_value({tag, "_time_max"}, int'(time_max), 0);
  endtask

  // Reset between edges must clear the outputs without waiting for the clock.
  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge update_clk);
    #1;
    reset = 1'b0;
  endtask

  // Holds start for 8 cycles; the game enters INGAME on the 7th edge.
  task automatic press_start();
    btn_start = 1'b1;
    idle(8);
    btn_start = 1'b0;
    idle(3);
  endtask

  task automatic random_phase(input int n);
    int hold [6];
    bit val [6];
    for (int i = 0; i < 6; i++) begin hold[i] = 0; val[i] = 1'b0; end
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (hold[i] == 0) begin
          if (i < 5) begin
            val[i]  = ($urandom_range(0, 3) == 0);
            hold[i] = val[i] ? $urandom_range(1, 8) : $urandom_range(1, 12);
          end else begin
            val[i]  = ($urandom_range(0, 9) == 0);
            hold[i] = $urandom_range(5, 40);
          end
        end
        hold[i]--;
      end
      {sw_test, btn_start, btn_right, btn_left, btn_down, btn_up} =
        {val[5], val[4], val[3], val[2], val[1], val[0]};
      game_over  = ($urandom_range(0, 99) == 0);
      game_won   = ($urandom_range(0, 149) == 0);
      tail_count = ($urandom_range(0, 49) == 0) ? W'(MT) : W'($urandom_range(0, MT - 1));
      step();
      if (c == n / 2) async_reset_check("rand_reset");
    end
    {sw_test, btn_start, btn_right, btn_left, btn_down, btn_up} = 6'b000000;
    game_over = 1'b0; game_won = 1'b0; tail_count = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge update_clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Start press: MENU -> INGAME on the 7th edge after first being sampled.
    btn_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 6) check_value("start_early", int'(game_state), 0);
      if (c == 7) begin
        check_value("start_state", int'(game_state), 1);
        check_value("start_dir", int'(direction), 2);
        check_value("start_time", int'(time_left), TL);
      end
    end
    btn_start = 1'b0;
    idle(10);

    // Reversal ignored, then a legal turn.
    btn_left = 1'b1; idle(8); btn_left = 1'b0; idle(4);
    check_value("reverse_ignored", int'(direction), 2);
    btn_up = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 6) check_value("turn_early", int'(direction), 2);
      if (c == 7) check_value("turn_up", int'(direction), 1);
    end
    btn_up = 1'b0; idle(4);

    // Glitches shorter than the debounce window are rejected.
    btn_left = 1'b1; step(); btn_left = 1'b0; idle(5);
    btn_left = 1'b1; idle(3); btn_left = 1'b0; idle(8);
    check_value("glitch_dir", int'(direction), 1);

    // Loss beats win in the same cycle, then start returns to MENU.
    game_over = 1'b1; game_won = 1'b1; step();
    check_value("over_prio", int'(game_state), 2);
    game_over = 1'b0; game_won = 1'b0; idle(2);
    btn_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 7) check_value("over_to_menu", int'(game_state), 0);
    end
    btn_start = 1'b0; idle(3);
    check_value("held_start_menu", int'(game_state), 0);

    // Test switch wins over start, and dropping it returns to MENU.
    sw_test = 1'b1; btn_start = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    check_value("test_enter", int'(game_state), 4);
    btn_start = 1'b0; idle(5);
    sw_test = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 6) check_value("test_hold", int'(game_state), 4);
    end
    check_value("test_exit", int'(game_state), 0);
    idle(3);

    // Asynchronous reset mid-game after turning away from RIGHT.
    press_start();
    btn_up = 1'b1; idle(8); btn_up = 1'b0; idle(2);
    check_value("pre_reset_dir", int'(direction), 1);
    async_reset_check("mid_reset");

    // Round timer runs out with idle inputs.
    btn_start = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    btn_start = 1'b0;
    check_value("timer_load", int'(time_left), TL);
    for (int c = 1; c <= TL; c++) step();
    check_value("timer_zero", int'(time_left), 0);
    check_value("timer_zero_state", int'(game_state), 1);
    check_value("timer_zero_max", int'(time_max), 0);
    step();
    check_value("timer_max", int'(time_max), 1);
    check_value("timer_max_state", int'(game_state), 1);
    step();
    check_value("timer_over", int'(game_state), 2);
    check_value("timer_hold", int'(time_left), 0);
    idle(3);

    random_phase(3000);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
